// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: sequences start, LSB-first data, optional parity and stop,
// one frame bit per bit-clock cycle, driving the downstream TX output mux select.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            Mux_Sel,
  output logic                  Ser_Data,
  output logic                  Par_Bit,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state, next_state;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    par_en_q;
  logic                    accept;
  logic                    last_bit;

  assign accept   = (state == S_IDLE) && Data_Valid;
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign Ser_Data = shift_reg[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:   next_state = Data_Valid ? S_START : S_IDLE;
      S_START:  next_state = S_DATA;
      S_DATA:   next_state = !last_bit ? S_DATA : (par_en_q ? S_PARITY : S_STOP);
      S_PARITY: next_state = S_STOP;
      S_STOP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Mux select and Busy decode from the state register only (Moore outputs).
  always_comb begin
    Mux_Sel = SEL_STOP;
    Busy    = 1'b1;
    case (state)
      S_IDLE:   begin Mux_Sel = SEL_STOP; Busy = 1'b0; end
      S_START:  Mux_Sel = SEL_START;
      S_DATA:   Mux_Sel = SEL_DATA;
      S_PARITY: Mux_Sel = SEL_PARITY;
      S_STOP:   Mux_Sel = SEL_STOP;
      default:  begin Mux_Sel = SEL_STOP; Busy = 1'b0; end
    endcase
  end

  // Payload and parity are frozen at acceptance so mid-frame input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      Par_Bit   <= 1'b0;
    end else if (accept) begin
      shift_reg <= P_DATA;
      bit_cnt   <= '0;
      par_en_q  <= PAR_EN;
      Par_Bit   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
    end else if (state == S_DATA) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: stimulus pushes the expected per-cycle
// frame outputs, a negedge monitor pops and compares while a frame is on the line.
module tb_uart_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [1:0] Mux_Sel;
  logic       Ser_Data;
  logic       Par_Bit;
  logic       Busy;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Mux_Sel    (Mux_Sel),
    .Ser_Data   (Ser_Data),
    .Par_Bit    (Par_Bit),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [1:0] mux;
    logic       busy;
    logic       chk_ser;
    logic       ser;
    logic       chk_par;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   frame_id = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_entry(input logic [1:0] mux, input logic busy,
                                     input logic chk_ser, input logic ser,
                                     input logic chk_par, input logic par);
    exp_t e;
    e.tag = frame_id; e.mux = mux; e.busy = busy;
    e.chk_ser = chk_ser; e.ser = ser; e.chk_par = chk_par; e.par = par;
    exp_q.push_back(e);
  endfunction

  // Whole frame: START, data LSB first, optional PARITY, STOP, then one IDLE cycle.
  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic par);
    frame_id++;
    push_entry(2'b00, 1'b1, 1'b0, 1'b0, pen, par);
    for (int i = 0; i < 8; i++) push_entry(2'b10, 1'b1, 1'b1, d[i], pen, par);
    if (pen) push_entry(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, par);
    push_entry(2'b01, 1'b1, 1'b0, 1'b0, pen, par);
    push_entry(2'b01, 1'b0, 1'b0, 1'b0, pen, par);
  endfunction

  always @(negedge clk) begin
    if (Busy || prev_busy) begin
      if (exp_q.size() == 0) begin
        check("spurious busy", 8'(Busy), 8'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("frame%0d mux_sel", e.tag), 8'(Mux_Sel), 8'(e.mux));
        check($sformatf("frame%0d busy", e.tag), 8'(Busy), 8'(e.busy));
        if (e.chk_ser) check($sformatf("frame%0d ser_data", e.tag), 8'(Ser_Data), 8'(e.ser));
        if (e.chk_par) check($sformatf("frame%0d par_bit", e.tag), 8'(Par_Bit), 8'(e.par));
      end
    end
    prev_busy = Busy;
  end

  // Returns one step after a rising edge with the controller idle.
  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (Busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle busy", 8'(Busy), 8'h0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic typ, input logic par);
    wait_idle();
    P_DATA = d; PAR_EN = pen; PAR_TYP = typ; Data_Valid = 1'b1;
    @(posedge clk);
    push_frame(d, pen, par);
    #1;
    Data_Valid = 1'b0; P_DATA = ~d; PAR_EN = ~pen; PAR_TYP = ~typ;
  endtask

  logic [7:0] hd [3] = '{8'h81, 8'h07, 8'h6E};
  logic       hp [3] = '{1'b0, 1'b1, 1'b1};
  logic       ht [3] = '{1'b0, 1'b0, 1'b1};
  logic       hx [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset mux_sel", 8'(Mux_Sel), 8'h1);
    check("reset busy", 8'(Busy), 8'h0);
    check("reset ser_data", 8'(Ser_Data), 8'h0);
    check("reset par_bit", 8'(Par_Bit), 8'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Abort mid-DATA: only START, d0, d1 are seen before reset, then line idles.
    wait_idle();
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge clk);
    frame_id++;
    push_entry(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_entry(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_entry(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_entry(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 Data_Valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort mux_sel", 8'(Mux_Sel), 8'h1);
    check("abort busy", 8'(Busy), 8'h0);
    check("abort ser_data", 8'(Ser_Data), 8'h0);
    check("abort par_bit", 8'(Par_Bit), 8'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);

    // Valid pulse with 0xFF during DATA of a 0x00 frame must be dropped.
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0;
    @(posedge clk);
    #1 Data_Valid = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);

    // Data_Valid held high: frames every DATA_WIDTH+3 (+1 with parity) cycles.
    wait_idle();
    P_DATA = hd[0]; PAR_EN = hp[0]; PAR_TYP = ht[0]; Data_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      push_frame(hd[i], hp[i], hx[i]);
      #1;
      if (i < 2) begin
        P_DATA = hd[i+1]; PAR_EN = hp[i+1]; PAR_TYP = ht[i+1];
        repeat (10 + (hp[i] ? 1 : 0)) @(posedge clk);
      end else begin
        Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      end
    end

    wait_idle();
    repeat (4) @(posedge clk);
    check("scoreboard drained", 8'(exp_q.size()), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
